// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 4-stage pipeline (Fetch, RegFile Read, Execute, RegFile Write).
// Tracks pending register writes and holds stage 2 on RAW/WAW hazards.
// Squashes the younger stages for BR_PENALTY cycles after a taken branch.
// Optional feature macro: HAZARD_PERF_EN adds saturating stall/flush cycle counters;
// without it stall_cycles/flush_cycles are tied to zero and no counter flops exist.
module pipeline_hazard_ctrl #(
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned REG_W      = 3,
  parameter int unsigned BR_PENALTY = 2,
  parameter int unsigned PERF_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_src_a,
  input  logic [REG_W-1:0]  id_src_b,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic [REG_W-1:0]  id_dst,
  input  logic              id_dst_wr,
  input  logic              ex_br_valid,
  input  logic              ex_br_taken,
  input  logic              wb_wr,
  input  logic [REG_W-1:0]  wb_dst,
  output logic              pc_enable,
  output logic              if_id_enable,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              issue,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_cycles
);

  localparam int unsigned CNT_W = 3;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(BR_PENALTY - 1);

  // Elaboration-time sanity on parameters
  generate
    if (BR_PENALTY < 1 || BR_PENALTY > 7) begin : g_bad_penalty
      $error("BR_PENALTY must be in 1..7");
    end
    if ((2 ** REG_W) < NUM_REGS) begin : g_bad_reg_w
      $error("REG_W too narrow for NUM_REGS");
    end
  endgenerate

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [CNT_W-1:0]    flush_cnt;
  logic [CNT_W-1:0]    flush_cnt_nxt;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic [NUM_REGS-1:0] pend_eff;
  logic                br_take;
  logic                hazard;

  // Look up a scoreboard bit; indices beyond NUM_REGS are never pending
  function automatic logic reg_pend(input logic [NUM_REGS-1:0] vec,
                                    input logic [REG_W-1:0]    idx);
    logic hit;
    hit = 1'b0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (idx == REG_W'(r)) hit = vec[r];
    end
    return hit;
  endfunction

  assign br_take = ex_br_valid & ex_br_taken;

  // Effective pending view: a same-cycle writeback resolves the hazard (write-before-read regfile)
  always_comb begin
    pend_eff = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      pend_eff[r] = pending[r] & ~(wb_wr & (wb_dst == REG_W'(r)));
    end
  end

  // RAW on either used source, WAW on the destination
  always_comb begin
    hazard = id_valid & ((id_use_a  & reg_pend(pend_eff, id_src_a)) |
                         (id_use_b  & reg_pend(pend_eff, id_src_b)) |
                         (id_dst_wr & reg_pend(pend_eff, id_dst)));
  end

  // Next-state and pipeline control outputs; taken branch dominates, reset forces a safe pattern
  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b1;
    issue         = 1'b0;

    if (br_take) begin
      if_id_flush   = 1'b1;
      state_nxt     = ST_FLUSH;
      flush_cnt_nxt = FLUSH_LOAD;
    end else begin
      case (state)
        ST_FLUSH: begin
          if_id_flush = 1'b1;
          if (flush_cnt == '0) begin
            state_nxt = ST_RUN;
          end else begin
            flush_cnt_nxt = flush_cnt - CNT_W'(1);
          end
        end
        default: begin
          // RUN and STALL share behaviour: stall while hazard, issue as soon as it clears
          if (hazard) begin
            pc_enable    = 1'b0;
            if_id_enable = 1'b0;
            state_nxt    = ST_STALL;
          end else begin
            issue        = id_valid;
            id_ex_bubble = ~id_valid;
            state_nxt    = ST_RUN;
          end
        end
      endcase
    end

    if (!reset) begin
      pc_enable    = 1'b0;
      if_id_enable = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      issue        = 1'b0;
    end
  end

  // Scoreboard update: writeback clears, an issuing writer sets; set wins on collision
  always_comb begin
    pending_nxt = pending;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (wb_wr && (wb_dst == REG_W'(r))) pending_nxt[r] = 1'b0;
      if (issue && id_dst_wr && (id_dst == REG_W'(r))) pending_nxt[r] = 1'b1;
    end
  end

  // State, flush counter and scoreboard registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
      pending   <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      pending   <= pending_nxt;
    end
  end

`ifdef HAZARD_PERF_EN
  logic              stall_evt;
  logic              flush_evt;
  logic [PERF_W-1:0] stall_q;
  logic [PERF_W-1:0] flush_q;

  assign stall_evt = reset & ~br_take & (state != ST_FLUSH) & hazard;
  assign flush_evt = reset & if_id_flush;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) stall_q <= stall_q + PERF_W'(1);
      if (flush_evt && (flush_q != '1)) flush_q <= flush_q + PERF_W'(1);
    end
  end

  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule
